// File: rtl/sram_pkg.sv
// Shared widths, FSM state encoding and request record for the SRAM request controller.
// The VSETUP..VRELEASE states exist only when SRAM_WRITE_VERIFY_EN is defined.
package sram_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 32;

    typedef enum logic [3:0] {
        IDLE, SETUP, PULSE, HOLD, RELEASE, RESP
`ifdef SRAM_WRITE_VERIFY_EN
        , VSETUP, VPULSE, VHOLD, VRELEASE
`endif
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    function automatic int cnt_w(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/sram_req_ctrl_if.sv
// Request/response handshake plus SRAM macro pins, bundled for the controller.
// slave = controller side, master = core / SRAM side.
interface sram_req_ctrl_if;
    import sram_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_addr_ready;
    logic              sram_read_pulse;
    logic              sram_write_pulse;
    logic [DATA_W-1:0] sram_datain;
    logic [DATA_W-1:0] sram_dataout;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready, sram_dataout,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output sram_addr, sram_addr_ready, sram_read_pulse, sram_write_pulse, sram_datain
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready, sram_dataout,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  sram_addr, sram_addr_ready, sram_read_pulse, sram_write_pulse, sram_datain
    );

endinterface

// File: rtl/sram_phase_timer.sv
// Loadable down-counter timing the SETUP/PULSE phases; o_done is high while the count is 0.
module sram_phase_timer #(
    parameter int CNT_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_val,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst)                r_cnt <= '0;
        else if (i_load)        r_cnt <= i_val;
        else if (r_cnt != '0)   r_cnt <= r_cnt - CNT_W'(1);
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/sram_req_ctrl.sv
// Valid/ready front end for the 128x32 pulse-strobed SRAM macro.
// Optional write read-back verify pass: define SRAM_WRITE_VERIFY_EN.
module sram_req_ctrl
    import sram_pkg::*;
#(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 1
) (
    input  logic           clk,
    input  logic           rst,
    sram_req_ctrl_if.slave io_bus
);

    localparam int CNT_W = cnt_w(SETUP_CYC, PULSE_CYC);

    state_t            r_state, w_next;
    req_t              r_req;
    logic              w_load, w_done;
    logic [CNT_W-1:0]  w_load_val;
    logic              r_addr_ready, r_rd_pulse, r_wr_pulse, r_rsp_valid;
    logic              w_addr_ready_d, w_rd_pulse_d, w_wr_pulse_d, w_rsp_valid_d, w_cap;
    logic [DATA_W-1:0] r_rdata;
    logic              w_accept, w_rsp_hs;

    assign w_accept = (r_state == IDLE) && io_bus.req_valid;
    assign w_rsp_hs = r_rsp_valid && io_bus.rsp_ready;

    sram_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_val  (w_load_val),
        .o_done (w_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_req   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) r_req <= '{we: io_bus.req_we, addr: io_bus.req_addr, wdata: io_bus.req_wdata};
        end
    end

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        case (r_state)
            IDLE:    if (w_accept) begin w_next = SETUP; w_load = 1'b1; w_load_val = CNT_W'(SETUP_CYC - 1); end
            SETUP:   if (w_done) begin w_next = PULSE; w_load = 1'b1; w_load_val = CNT_W'(PULSE_CYC - 1); end
            PULSE:   if (w_done) w_next = HOLD;
            HOLD:    w_next = RELEASE;
`ifdef SRAM_WRITE_VERIFY_EN
            RELEASE: if (r_req.we) begin w_next = VSETUP; w_load = 1'b1; w_load_val = CNT_W'(SETUP_CYC - 1); end
                     else w_next = RESP;
            VSETUP:  if (w_done) begin w_next = VPULSE; w_load = 1'b1; w_load_val = CNT_W'(PULSE_CYC - 1); end
            VPULSE:  if (w_done) w_next = VHOLD;
            // Two-cycle release pads the verify pass to a full request slot.
            VHOLD:   begin w_next = VRELEASE; w_load = 1'b1; w_load_val = CNT_W'(1); end
            VRELEASE: if (w_done) w_next = RESP;
`else
            RELEASE: w_next = RESP;
`endif
            RESP:    if (w_rsp_hs) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Pins trail the FSM by one register stage, so the pin-visible HOLD is the RELEASE state.
    always_comb begin
        w_addr_ready_d = (r_state == SETUP) || (r_state == PULSE) || (r_state == HOLD);
        w_rd_pulse_d   = (r_state == PULSE) && !r_req.we;
        w_wr_pulse_d   = (r_state == PULSE) && r_req.we;
        w_rsp_valid_d  = (r_state == RESP) && !w_rsp_hs;
        w_cap          = (r_state == RELEASE) && !r_req.we;
`ifdef SRAM_WRITE_VERIFY_EN
        w_addr_ready_d = w_addr_ready_d || (r_state == VSETUP) || (r_state == VPULSE) || (r_state == VHOLD);
        w_rd_pulse_d   = w_rd_pulse_d || (r_state == VPULSE);
        w_cap          = w_cap || ((r_state == VRELEASE) && !w_done);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr_ready <= 1'b0;
            r_rd_pulse   <= 1'b0;
            r_wr_pulse   <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rdata      <= '0;
        end else begin
            r_addr_ready <= w_addr_ready_d;
            r_rd_pulse   <= w_rd_pulse_d;
            r_wr_pulse   <= w_wr_pulse_d;
            r_rsp_valid  <= w_rsp_valid_d;
            if (w_accept)   r_rdata <= '0;
            else if (w_cap) r_rdata <= io_bus.sram_dataout;
        end
    end

`ifdef SRAM_WRITE_VERIFY_EN
    logic r_err;
    always_ff @(posedge clk) begin
        if (rst || w_accept) r_err <= 1'b0;
        else if (w_cap && r_req.we) r_err <= (io_bus.sram_dataout != r_req.wdata);
    end
    assign io_bus.rsp_err = r_err;
`else
    assign io_bus.rsp_err = 1'b0;
`endif

    assign io_bus.req_ready        = (r_state == IDLE);
    assign io_bus.rsp_valid        = r_rsp_valid;
    assign io_bus.rsp_rdata        = r_rdata;
    assign io_bus.sram_addr        = r_req.addr;
    assign io_bus.sram_datain      = r_req.wdata;
    assign io_bus.sram_addr_ready  = r_addr_ready;
    assign io_bus.sram_read_pulse  = r_rd_pulse;
    assign io_bus.sram_write_pulse = r_wr_pulse;

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Self-checking bench for sram_req_ctrl: behavioural SRAM plus a scoreboard memory.
// Define SRAM_WRITE_VERIFY_EN to exercise the verify pass with a bit-0 stuck-at-0 SRAM.
module tb_sram_req_ctrl;
    import sram_pkg::*;

    localparam int S = 1;
    localparam int P = 1;
`ifdef SRAM_WRITE_VERIFY_EN
    localparam bit VFY = 1'b1;
    localparam logic [DATA_W-1:0] STUCK_MASK = 32'hFFFF_FFFE;
`else
    localparam bit VFY = 1'b0;
    localparam logic [DATA_W-1:0] STUCK_MASK = 32'hFFFF_FFFF;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_req_ctrl_if bus();

    sram_req_ctrl #(.SETUP_CYC(S), .PULSE_CYC(P)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    logic [DATA_W-1:0] sram_mem [2**ADDR_W];
    logic [DATA_W-1:0] ref_mem  [2**ADDR_W];
    int n_cmp = 0;
    int n_bad = 0;
    int proto_bad = 0;

    // Behavioural macro: strobes sampled on the rising edge.
    always @(posedge clk) begin
        if (bus.sram_write_pulse) sram_mem[bus.sram_addr] <= bus.sram_datain & STUCK_MASK;
        if (bus.sram_read_pulse)  bus.sram_dataout <= sram_mem[bus.sram_addr];
    end

    always @(negedge clk) begin
        if ((bus.sram_read_pulse && bus.sram_write_pulse) ||
            ((bus.sram_read_pulse || bus.sram_write_pulse) && !bus.sram_addr_ready))
            proto_bad++;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pin pattern n cycles after the accept edge: {addr_ready, read_pulse, write_pulse}.
    function automatic logic [2:0] exp_pins(input int n, input bit we);
        bit ar, rp, wp, in_pulse;
        in_pulse = (n >= S + 1) && (n <= S + P);
        ar = (n >= 1) && (n <= S + P + 1);
        wp = we && in_pulse;
        rp = !we && in_pulse;
        if (VFY && we) begin
            ar = ar || ((n >= S + P + 3) && (n <= 2*S + 2*P + 3));
            rp = (n >= 2*S + P + 3) && (n <= 2*S + 2*P + 2);
        end
        return {ar, rp, wp};
    endfunction

    task automatic xact(input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input int stall);
        int n, bad, lat;
        logic [DATA_W-1:0] exp_rd, rd0;
        bit exp_err;
        lat = (we && VFY) ? 2*(3 + S + P) : 3 + S + P;
        if (we) ref_mem[a] = d & STUCK_MASK;
        exp_rd  = we ? (VFY ? (d & STUCK_MASK) : '0) : ref_mem[a];
        exp_err = we && VFY && ((d & STUCK_MASK) != d);

        n = 0;
        while (!bus.req_ready && n < 64) begin @(negedge clk); n++; end
        chk("req_ready", bus.req_ready, 1);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a; bus.req_wdata = d;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0; bus.req_we = 1'($urandom);
        bus.req_addr = ADDR_W'($urandom); bus.req_wdata = $urandom;

        n = 0; bad = 0;
        while (!bus.rsp_valid && n < 64) begin
            if ({bus.sram_addr_ready, bus.sram_read_pulse, bus.sram_write_pulse} !== exp_pins(n, we)) bad++;
            if (bus.sram_addr !== a || (we && bus.sram_datain !== d)) bad++;
            @(negedge clk); n++;
        end
        chk("pins", bad, 0);
        chk("latency", n, lat);
        chk("rdata", bus.rsp_rdata, exp_rd);
        chk("err", bus.rsp_err, exp_err);

        rd0 = bus.rsp_rdata;
        for (int s = 0; s < stall; s++) begin
            bus.req_valid = 1'b1;
            @(negedge clk);
            chk("stall", {bus.rsp_valid, bus.req_ready, bus.rsp_rdata}, {1'b1, 1'b0, rd0});
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("handshake", {bus.rsp_valid, bus.req_ready, bus.sram_addr_ready}, 3'b010);
    endtask

    initial begin
        int bad;
        logic [DATA_W-1:0] d;
        for (int i = 0; i < 2**ADDR_W; i++) begin sram_mem[i] = '0; ref_mem[i] = '0; end
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            chk("idle", {bus.sram_addr_ready, bus.sram_read_pulse, bus.sram_write_pulse, bus.sram_addr,
                         bus.sram_datain, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.req_ready}, 128'd1);
            @(negedge clk);
        end

        xact(1'b1, 7'h05, 32'hDEAD_BEEF, 0);
        xact(1'b0, 7'h05, '0, 0);
        xact(1'b0, 7'h05, '0, 4);
        xact(1'b1, 7'h03, 32'h0000_0001, 0);
        xact(1'b0, 7'h03, '0, 0);

        // Reset while write_pulse is on the pins: strobes drop on that edge, no response.
        d = $urandom;
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 7'h11; bus.req_wdata = d;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pulse_pre_rst", bus.sram_write_pulse, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid", {bus.sram_addr_ready, bus.sram_write_pulse, bus.sram_read_pulse,
                        bus.rsp_valid, bus.req_ready}, 5'b00001);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.rsp_valid || bus.sram_addr_ready) bad++;
            @(negedge clk);
        end
        chk("rst_no_rsp", bad, 0);

        for (int i = 0; i < 2**ADDR_W; i++) xact(1'b1, ADDR_W'(i), i * 32'h0101_0101, 0);
        for (int i = 0; i < 2**ADDR_W; i++) xact(1'b0, ADDR_W'(i), '0, 0);

        for (int i = 0; i < 60; i++)
            xact(1'($urandom_range(0, 1)), ADDR_W'($urandom), $urandom, $urandom_range(0, 3));

        chk("protocol", proto_bad, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
